// File: rtl/fft_peak_bin.sv
// fft_peak_bin
// Streaming peak-bin detector for one FFT output frame per i_sop. For each
// bin in the lower half-spectrum it forms |re|+|im| and tracks the strongest
// bin. The result of the last completed frame is held on o_bin/o_mag, so the
// downstream threshold/jump stage can sample it on any cycle.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - asynchronous, active-high reset
//   i_valid  - one FFT bin presented this cycle
//   i_sop    - qualifies i_valid, marks bin 0 of a frame
//   i_real   - signed real part (DW bits)
//   i_imag   - signed imaginary part (DW bits)
//   o_bin    - peak bin index of the last completed frame (LGFFT-1 bits), held
//   o_mag    - peak magnitude of the last completed frame (DW+1 bits), held
//   o_valid  - one-cycle pulse when o_bin/o_mag update
//   o_drop   - one-cycle pulse when a frame is aborted by an early i_sop
module fft_peak_bin #(
  parameter int FFT       = 1024,
  parameter int HFFT      = FFT / 2,
  parameter int LGFFT     = 10,
  parameter int DW        = 16,
  parameter int MINBIN    = 1,
  parameter int MAGTHRESH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_sop,
  input  logic signed [DW-1:0] i_real,
  input  logic signed [DW-1:0] i_imag,
  output logic [LGFFT-2:0]     o_bin,
  output logic [DW:0]          o_mag,
  output logic                 o_valid,
  output logic                 o_drop
);

  typedef enum logic [1:0] {IDLE, SCAN, SKIP} state_t;

  localparam logic [LGFFT-1:0] ONE       = LGFFT'(1);
  localparam logic [LGFFT-1:0] MIN_B     = LGFFT'(MINBIN);
  localparam logic [LGFFT-1:0] LAST_SCAN = LGFFT'(HFFT - 1);
  localparam logic [LGFFT-1:0] LAST_BIN  = LGFFT'(FFT - 1);
  localparam logic [DW:0]      THRESH    = (DW + 1)'(MAGTHRESH);

  state_t           state_q, state_d;
  logic [LGFFT-1:0] bin_q, bin_d;

  // Per-sample decode from the frame FSM, registered into stage 1
  logic             acc;
  logic             first;
  logic             last;
  logic             abort;
  logic             cmp;
  logic [LGFFT-1:0] cur_bin;

  // Stage 1 registers
  logic             s1_valid;
  logic             s1_first;
  logic             s1_last;
  logic             s1_abort;
  logic             s1_cmp;
  logic [DW:0]      s1_mag;
  logic [LGFFT-2:0] s1_bin;

  // Stage 2 trackers
  logic [DW:0]      best_mag;
  logic [LGFFT-2:0] best_bin;
  logic             pub_pend;

  logic [DW:0]      base_mag;
  logic [LGFFT-2:0] base_bin;
  logic             take;

  // Approximate magnitude. Components are sign-extended by one bit first so
  // that negating the most negative value cannot overflow.
  logic [DW:0] real_ext, imag_ext, abs_real, abs_imag, mag;

  assign real_ext = {i_real[DW-1], i_real};
  assign imag_ext = {i_imag[DW-1], i_imag};
  assign abs_real = i_real[DW-1] ? -real_ext : real_ext;
  assign abs_imag = i_imag[DW-1] ? -imag_ext : imag_ext;
  assign mag      = abs_real + abs_imag;

  // Frame state and bin counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
    end
  end

  // Frame sequencing. bin_q holds the index the next accepted sample will
  // take; any i_sop sample is bin 0 and restarts the count at 1. In SCAN an
  // i_sop abandons the unfinished frame, in SKIP it is an ordinary restart.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc     = 1'b0;
    first   = 1'b0;
    last    = 1'b0;
    abort   = 1'b0;
    cur_bin = bin_q;
    case (state_q)
      IDLE: begin
        if (i_valid && i_sop) begin
          acc     = 1'b1;
          first   = 1'b1;
          cur_bin = '0;
          bin_d   = ONE;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (i_valid) begin
          acc = 1'b1;
          if (i_sop) begin
            abort   = 1'b1;
            first   = 1'b1;
            cur_bin = '0;
            bin_d   = ONE;
          end else begin
            bin_d = bin_q + ONE;
            if (bin_q == LAST_SCAN) begin
              last    = 1'b1;
              state_d = SKIP;
            end
          end
        end
      end
      SKIP: begin
        if (i_valid) begin
          acc = 1'b1;
          if (i_sop) begin
            first   = 1'b1;
            cur_bin = '0;
            bin_d   = ONE;
            state_d = SCAN;
          end else if (bin_q == LAST_BIN) begin
            bin_d   = '0;
            state_d = IDLE;
          end else begin
            bin_d = bin_q + ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        bin_d   = '0;
      end
    endcase
    cmp = acc && (cur_bin >= MIN_B) && (cur_bin <= LAST_SCAN);
  end

  // Stage 1: register the magnitude alongside its bin index and frame tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_abort <= 1'b0;
      s1_cmp   <= 1'b0;
      s1_mag   <= '0;
      s1_bin   <= '0;
    end else begin
      s1_valid <= acc;
      s1_first <= first;
      s1_last  <= last;
      s1_abort <= abort;
      s1_cmp   <= cmp;
      s1_mag   <= mag;
      s1_bin   <= cur_bin[LGFFT-2:0];
    end
  end

  // The first sample of a frame compares against a cleared tracker rather
  // than the previous frame's best. Strict greater-than keeps the lowest
  // index on ties.
  always_comb begin
    base_mag = s1_first ? '0 : best_mag;
    base_bin = s1_first ? '0 : best_bin;
    take     = s1_valid && s1_cmp && (s1_mag > base_mag);
  end

  // Stage 2: best trackers plus the publish request and drop pulse. A
  // publish pending here is consumed one edge later, before a following
  // frame's clear can reach the trackers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_mag <= '0;
      best_bin <= '0;
      pub_pend <= 1'b0;
      o_drop   <= 1'b0;
    end else begin
      if (s1_valid) begin
        best_mag <= take ? s1_mag : base_mag;
        best_bin <= take ? s1_bin : base_bin;
      end
      pub_pend <= s1_valid && s1_last;
      o_drop   <= s1_valid && s1_abort;
    end
  end

  // Publish: weak peaks report bin 0 but still carry their magnitude
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_bin   <= '0;
      o_mag   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= pub_pend;
      if (pub_pend) begin
        o_mag <= best_mag;
        o_bin <= (best_mag >= THRESH) ? best_bin : '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_bin.sv
// tb_fft_peak_bin
// Directed bench for fft_peak_bin: frames are built in a sparse table and
// streamed bin by bin; a negedge monitor logs every o_valid/o_drop pulse and
// any change of o_bin/o_mag outside a publish.
module tb_fft_peak_bin;

  localparam int FFT = 1024;
  localparam int HFFT = 512;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_valid = 1'b0;
  logic               i_sop = 1'b0;
  logic signed [15:0] i_real = '0;
  logic signed [15:0] i_imag = '0;
  logic [8:0]         o_bin;
  logic [16:0]        o_mag;
  logic               o_valid;
  logic               o_drop;

  fft_peak_bin dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_sop   (i_sop),
    .i_real  (i_real),
    .i_imag  (i_imag),
    .o_bin   (o_bin),
    .o_mag   (o_mag),
    .o_valid (o_valid),
    .o_drop  (o_drop)
  );

  always #5 clk = ~clk;

  // Posedge count; at a negedge following edge N this reads N
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int pubBin[$];
  int pubMag[$];
  int pubCyc[$];
  int dropCyc[$];
  int holdViol = 0;
  logic [8:0]  prevBin = '0;
  logic [16:0] prevMag = '0;

  logic signed [15:0] reTab[FFT];
  logic signed [15:0] imTab[FFT];
  int sopEdge = 0;
  int lastEdge = 0;

  // Output monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst && !o_valid && (o_bin !== prevBin || o_mag !== prevMag))
      holdViol++;
    prevBin = o_bin;
    prevMag = o_mag;
    if (o_valid === 1'b1) begin
      pubBin.push_back(int'(o_bin));
      pubMag.push_back(int'(o_mag));
      pubCyc.push_back(cyc);
    end
    if (o_drop === 1'b1) dropCyc.push_back(cyc);
  end

  function automatic int qAt(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic s,
                               input logic signed [15:0] re,
                               input logic signed [15:0] im);
    @(negedge clk);
    i_valid = v;
    i_sop   = s;
    i_real  = re;
    i_imag  = im;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 16'sd0, 16'sd0);
    #1;
  endtask

  task automatic clearTab();
    for (int b = 0; b < FFT; b++) begin
      reTab[b] = '0;
      imTab[b] = '0;
    end
  endtask

  // Streams bins 0..nbins-1 from the table; the acceptance edge of bin 0 and
  // bin HFFT-1 is recorded for latency checks
  task automatic sendFrame(input int nbins, input bit gaps);
    for (int b = 0; b < nbins; b++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 1'b0, 16'sd0, 16'sd0);
      applyStimulus(1'b1, (b == 0), reTab[b], imTab[b]);
      if (b == 0) sopEdge = cyc + 1;
      if (b == HFFT - 1) lastEdge = cyc + 1;
    end
  endtask

  int gSop;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_o_bin", 32'(o_bin), 32'd0);
    checkOutput("rst_o_mag", 32'(o_mag), 32'd0);
    checkOutput("rst_o_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_o_drop", 32'(o_drop), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // A: single tone at bin 300, latency and hold through the upper half
    clearTab();
    reTab[300] = 16'sd3000;
    imTab[300] = -16'sd1000;
    sendFrame(FFT, 1'b0);
    idle(4);
    checkOutput("A_count", 32'(pubBin.size()), 32'd1);
    checkOutput("A_bin", 32'(qAt(pubBin, 0)), 32'd300);
    checkOutput("A_mag", 32'(qAt(pubMag, 0)), 32'd4000);
    checkOutput("A_latency", 32'(qAt(pubCyc, 0)), 32'(lastEdge + 2));
    checkOutput("A_held_bin", 32'(o_bin), 32'd300);
    checkOutput("A_held_mag", 32'(o_mag), 32'd4000);
    checkOutput("A_valid_low", 32'(o_valid), 32'd0);

    // B: DC and upper-half bins are never candidates
    clearTab();
    reTab[0]   = 16'sd30000;
    reTab[100] = 16'sd2000;
    reTab[700] = 16'sd32767;
    sendFrame(FFT, 1'b0);
    idle(3);
    checkOutput("B_bin", 32'(qAt(pubBin, 1)), 32'd100);
    checkOutput("B_mag", 32'(qAt(pubMag, 1)), 32'd2000);

    // C: tie between bins 200 and 400 keeps the lower index
    clearTab();
    reTab[200] = 16'sd1500;
    imTab[200] = 16'sd500;
    reTab[400] = 16'sd1500;
    imTab[400] = 16'sd500;
    sendFrame(FFT, 1'b0);
    idle(3);
    checkOutput("C_tie_bin", 32'(qAt(pubBin, 2)), 32'd200);
    checkOutput("C_tie_mag", 32'(qAt(pubMag, 2)), 32'd2000);

    // D: peak of 800 is below threshold
    clearTab();
    reTab[123] = -16'sd500;
    imTab[123] = 16'sd300;
    sendFrame(FFT, 1'b0);
    idle(3);
    checkOutput("D_weak_bin", 32'(qAt(pubBin, 3)), 32'd0);
    checkOutput("D_weak_mag", 32'(qAt(pubMag, 3)), 32'd800);

    // E: most negative components
    clearTab();
    reTab[50] = 16'sh8000;
    imTab[50] = 16'sh8000;
    reTab[51] = 16'sd32767;
    imTab[51] = 16'sd32767;
    sendFrame(FFT, 1'b0);
    idle(3);
    checkOutput("E_bin", 32'(qAt(pubBin, 4)), 32'd50);
    checkOutput("E_mag", 32'(qAt(pubMag, 4)), 32'd65536);

    // F/G: i_sop at bin 250 aborts F; G restarts immediately
    clearTab();
    reTab[100] = 16'sd5000;
    sendFrame(250, 1'b0);
    clearTab();
    imTab[10] = -16'sd3000;
    sendFrame(FFT, 1'b0);
    gSop = sopEdge;
    idle(3);
    checkOutput("G_drop_count", 32'(dropCyc.size()), 32'd1);
    checkOutput("G_drop_time", 32'(qAt(dropCyc, 0)), 32'(gSop + 1));
    checkOutput("G_pub_count", 32'(pubBin.size()), 32'd6);
    checkOutput("G_bin", 32'(qAt(pubBin, 5)), 32'd10);
    checkOutput("G_mag", 32'(qAt(pubMag, 5)), 32'd3000);

    // H/I: i_sop at bin 800 is a plain restart
    clearTab();
    imTab[77] = 16'sd1200;
    sendFrame(800, 1'b0);
    clearTab();
    reTab[33] = 16'sd1100;
    sendFrame(FFT, 1'b0);
    idle(3);
    checkOutput("I_no_drop", 32'(dropCyc.size()), 32'd1);
    checkOutput("H_bin", 32'(qAt(pubBin, 6)), 32'd77);
    checkOutput("H_mag", 32'(qAt(pubMag, 6)), 32'd1200);
    checkOutput("I_bin", 32'(qAt(pubBin, 7)), 32'd33);
    checkOutput("I_mag", 32'(qAt(pubMag, 7)), 32'd1100);

    // J/K: back-to-back frames with random input gaps; K peaks at bin 511
    clearTab();
    reTab[400] = -16'sd2000;
    imTab[400] = -16'sd2000;
    sendFrame(FFT, 1'b1);
    clearTab();
    imTab[511] = 16'sd1500;
    sendFrame(FFT, 1'b1);
    idle(3);
    checkOutput("JK_count", 32'(pubBin.size()), 32'd10);
    checkOutput("J_bin", 32'(qAt(pubBin, 8)), 32'd400);
    checkOutput("J_mag", 32'(qAt(pubMag, 8)), 32'd4000);
    checkOutput("K_bin", 32'(qAt(pubBin, 9)), 32'd511);
    checkOutput("K_mag", 32'(qAt(pubMag, 9)), 32'd1500);
    checkOutput("K_latency", 32'(qAt(pubCyc, 9)), 32'(lastEdge + 2));

    // L: reset in the middle of a frame, then M at exactly the threshold
    clearTab();
    reTab[20] = 16'sd9000;
    sendFrame(301, 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    i_sop   = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    idle(3);
    checkOutput("L_rst_bin", 32'(o_bin), 32'd0);
    checkOutput("L_rst_mag", 32'(o_mag), 32'd0);
    checkOutput("L_no_pub", 32'(pubBin.size()), 32'd10);
    checkOutput("L_no_drop", 32'(dropCyc.size()), 32'd1);
    clearTab();
    imTab[1] = 16'sd1000;
    reTab[5] = 16'sd1024;
    sendFrame(FFT, 1'b0);
    idle(3);
    checkOutput("M_bin", 32'(qAt(pubBin, 10)), 32'd5);
    checkOutput("M_mag", 32'(qAt(pubMag, 10)), 32'd1024);
    checkOutput("M_out_bin", 32'(o_bin), 32'd5);
    checkOutput("hold_violations", 32'(holdViol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_peak_bin.md
# fft_peak_bin

Streaming peak-bin detector that sits directly upstream of the frequency-threshold/jump stage. It consumes one FFT output frame per `i_sop`, computes an approximate magnitude `|re|+|im|` for each bin in the lower half-spectrum, and tracks the index of the strongest bin. The result is held on `o_bin` until the next frame completes, so the downstream stage can sample it every cycle.

## Interface
- `FFT`, 1024, FFT frame length in bins
- `HFFT`, FFT/2, number of bins scanned (bins 0..HFFT-1)
- `LGFFT`, 10, log2(FFT)
- `DW`, 16, signed width of each FFT real/imag component
- `MINBIN`, 1, lowest bin eligible for peak (excludes DC)
- `MAGTHRESH`, 1024, minimum peak magnitude for a valid tone
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — asynchronous, active-high reset
- `i_valid` input 1 — one FFT bin presented this cycle
- `i_sop` input 1 — qualifies `i_valid`; marks bin 0 of a frame
- `i_real` input DW — signed real part
- `i_imag` input DW — signed imaginary part
- `o_bin` output LGFFT-1 — peak bin index of last completed frame, held
- `o_mag` output DW+1 — peak magnitude of last completed frame, held
- `o_valid` output 1 — one-cycle pulse when `o_bin`/`o_mag` update
- `o_drop` output 1 — one-cycle pulse when a frame is aborted by early `i_sop`

## Operation
- Magnitude: `mag = |i_real| + |i_imag|`, unsigned DW+1 bits. `|-2^(DW-1)| = 2^(DW-1)`, which fits without overflow.
- Pipeline: stage 1 registers `mag`, the bin index, and a valid/last tag. Stage 2 does compare/update.
- Bin counter (LGFFT bits) increments only on accepted samples (`i_valid=1`).
- States:
  - **IDLE**: ignore `i_valid` without `i_sop`. On `i_valid & i_sop`: bin=0, clear `best_mag=0`, `best_bin=0`, go to SCAN.
  - **SCAN**: on each accepted bin b with MINBIN ≤ b ≤ HFFT-1, replace best if `mag > best_mag` (strict, so the lowest index wins ties). Bins below MINBIN are counted but never compared. On accepting b=HFFT-1, schedule publish and go to SKIP.
  - **SKIP**: count bins HFFT..FFT-1 without comparing. On accepting b=FFT-1, go to IDLE.
- Publish: if `best_mag ≥ MAGTHRESH`, `o_bin=best_bin` and `o_mag=best_mag`; otherwise `o_bin=0` and `o_mag=best_mag`. Pulse `o_valid`. `o_bin` and `o_mag` do not change between publishes.
- Early `i_sop`:
  - During SCAN: abort the frame with no publish, pulse `o_drop`, and restart at bin 0 with that sample (re-clear best, stay in SCAN).
  - During SKIP: a normal restart with no `o_drop`, since the frame was already published. Go to SCAN with bin 0.
- Simultaneous events: if the publish of frame k is pending in stage 2 when frame k+1's `i_sop` arrives, frame k still publishes. The best trackers for frame k+1 start clean.
- Reset mid-frame: all state is cleared, the frame is lost, and there is no `o_drop`.

## Timing
- Reset values: `o_bin=0`, `o_mag=0`, `o_valid=0`, `o_drop=0`, state IDLE, counters 0.
- If bin HFFT-1 is accepted at edge N, `o_bin`/`o_mag` change and `o_valid=1` after edge N+2, for exactly one cycle.
- If the aborting `i_sop` is accepted at edge N, `o_drop=1` after edge N+1, for one cycle.
- Input gaps (`i_valid=0`) are allowed anywhere; no bin is consumed and latency is counted from the last accepted bin.
- No backpressure; every cycle can accept a bin. Back-to-back frames with zero gap are supported.

## Test plan
- Reset, then a frame of zeros except bin 300 = (3000, -1000) → `o_valid` pulse 2 cycles after bin 511, `o_bin=300`, `o_mag=4000`, held through the following 512 cycles.
- Frame with bin 0 = (30000,0), bin 100 = (2000,0), bin 700 = (32767,0) → `o_bin=100`, `o_mag=2000` (DC and upper half ignored).
- Bins 200 and 400 both = (1500,500) → `o_bin=200`. Separately, a frame whose peak is 800 → `o_bin=0`, `o_mag=800`.
- Bin 50 = (-32768,-32768) → `o_mag=65536`, `o_bin=50`.
- `i_sop` re-asserted at bin 250 of a frame → `o_drop` pulse, no `o_valid`, and the new frame publishes correctly. `i_sop` at bin 800 → no `o_drop`.
- Two back-to-back frames with random `i_valid` gaps, and `rst` asserted mid-frame → outputs return to 0 and the next full frame publishes normally.
